// File: rtl/wishbone_bus_if.sv
// Wishbone classic master bridging one CPU port (instruction or data)
// onto the bus; stalls the pipeline until the slave acknowledges.
module wishbone_bus_if #(
    parameter int unsigned STALL_IDX = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        BUSY           = 2'd1,
        WAIT_FOR_STALL = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic        stb_q, stb_d;
    logic        cyc_q, cyc_d;
    logic [31:0] rd_buf_q, rd_buf_d;

    logic stalled;
    logic unused_stall;

    assign stalled      = stall_i[STALL_IDX];
    assign unused_stall = ^stall_i;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        sel_d      = sel_q;
        cyc_d      = cyc_q;
        rd_buf_d   = rd_buf_q;
        stallreq_o = 1'b0;
        cpu_data_o = 32'h0;

        unique case (state_q)
            IDLE: begin
                stallreq_o = cpu_ce_i & ~flush_i;
                if (cpu_ce_i && !flush_i) begin
                    addr_d  = cpu_addr_i;
                    wdata_d = cpu_data_i;
                    we_d    = cpu_we_i;
                    sel_d   = cpu_sel_i;
                    cyc_d   = 1'b1;
                    state_d = BUSY;
                end else begin
                    addr_d  = 32'h0;
                    wdata_d = 32'h0;
                    we_d    = 1'b0;
                    sel_d   = 4'h0;
                    cyc_d   = 1'b0;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    // flush beats a simultaneous ack: the access is dropped
                    addr_d   = 32'h0;
                    wdata_d  = 32'h0;
                    we_d     = 1'b0;
                    sel_d    = 4'h0;
                    cyc_d    = 1'b0;
                    rd_buf_d = 32'h0;
                    state_d  = IDLE;
                end else if (wb_ack_i) begin
                    addr_d   = 32'h0;
                    wdata_d  = 32'h0;
                    we_d     = 1'b0;
                    sel_d    = 4'h0;
                    cyc_d    = 1'b0;
                    rd_buf_d = wb_data_i;
                    state_d  = stalled ? WAIT_FOR_STALL : IDLE;
                    if (!we_q) begin
                        cpu_data_o = wb_data_i;
                    end
                end else begin
                    stallreq_o = 1'b1;
                end
            end
            WAIT_FOR_STALL: begin
                // pipeline is frozen elsewhere; keep replaying the data
                cpu_data_o = rd_buf_q;
                if (!stalled || flush_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        stb_d = cyc_d;

        if (!rst_n) begin
            stallreq_o = 1'b0;
            cpu_data_o = 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            we_q     <= 1'b0;
            sel_q    <= 4'h0;
            stb_q    <= 1'b0;
            cyc_q    <= 1'b0;
            rd_buf_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            stb_q    <= stb_d;
            cyc_q    <= cyc_d;
            rd_buf_q <= rd_buf_d;
        end
    end

    assign wb_addr_o = addr_q;
    assign wb_data_o = wdata_q;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_stb_o  = stb_q;
    assign wb_cyc_o  = cyc_q;

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Bench for wishbone_bus_if: each access is described by its timeline
// (ack delay, stall hold, flush point) and outputs are checked per cycle.
module tb_wishbone_bus_if;

    localparam int IDX = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;

    int total = 0;
    int bad   = 0;

    logic [70:0] obs_bus;
    assign obs_bus = {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
                      wb_addr_o, wb_data_o};

    always #5 clk = ~clk;

    wishbone_bus_if #(.STALL_IDX(IDX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .wb_addr_o  (wb_addr_o),
        .wb_data_o  (wb_data_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_data_i  (wb_data_i),
        .wb_ack_i   (wb_ack_i)
    );

    function automatic logic [5:0] rnd_stall(input bit mine);
        logic [5:0] s;
        s = 6'($urandom);
        s[IDX] = mine;
        return s;
    endfunction

    task automatic test_reset();
        rst_n      = 1'b0;
        cpu_ce_i   = 1'b1;
        flush_i    = 1'b0;
        cpu_we_i   = 1'b1;
        cpu_addr_i = 32'h1111_2222;
        cpu_data_i = 32'h3333_4444;
        cpu_sel_i  = 4'hF;
        wb_ack_i   = 1'b1;
        wb_data_i  = 32'h5555_6666;
        stall_i    = 6'h3F;
        #3;
        total++;
        if (obs_bus !== 71'h0) begin
            bad++;
            $display("FAIL reset_bus: got %h want 0", obs_bus);
        end
        total++;
        if (stallreq_o !== 1'b0 || cpu_data_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_cpu: got stallreq=%b data=%h want 0/0",
                     stallreq_o, cpu_data_o);
        end
        @(negedge clk);
        total++;
        if (obs_bus !== 71'h0 || stallreq_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_edge: got bus=%h sr=%b want 0/0",
                     obs_bus, stallreq_o);
        end
        cpu_ce_i = 1'b0;
        wb_ack_i = 1'b0;
        stall_i  = 6'h0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (obs_bus !== 71'h0 || stallreq_o !== 1'b0
            || cpu_data_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_release: got bus=%h sr=%b d=%h want 0",
                     obs_bus, stallreq_o, cpu_data_o);
        end
    endtask

    task automatic test_idle_flush();
        @(posedge clk);
        #1;
        cpu_ce_i   = 1'b1;
        flush_i    = 1'b1;
        cpu_addr_i = $urandom;
        @(negedge clk);
        total++;
        if (stallreq_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_flush_sr: got %b want 0", stallreq_o);
        end
        @(posedge clk);
        #1;
        cpu_ce_i = 1'b0;
        flush_i  = 1'b0;
        @(negedge clk);
        total++;
        if (obs_bus !== 71'h0) begin
            bad++;
            $display("FAIL idle_flush_bus: got %h want 0", obs_bus);
        end
    endtask

    // dly: cycles from request edge to ack cycle (>=1)
    // nwait: cycles spent waiting for the pipeline stall to clear
    // fl_end: flush in the last BUSY cycle, ack random
    // fl_wait: flush in the first wait cycle while still stalled
    task automatic test_access(input bit we, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] rd,
                               input logic [3:0] sel, input int dly,
                               input int nwait, input bit fl_end,
                               input bit fl_wait);
        logic [70:0] exp_bus;
        logic [31:0] exp_d;
        int          n;
        exp_bus = {1'b1, 1'b1, we, sel, a, d};
        n = fl_wait ? 1 : nwait;
        @(posedge clk);
        #1;
        cpu_ce_i   = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = a;
        cpu_data_i = d;
        cpu_sel_i  = sel;
        flush_i    = 1'b0;
        wb_ack_i   = 1'b0;
        wb_data_i  = $urandom;
        stall_i    = rnd_stall(1'b0);
        @(negedge clk);
        total++;
        if (stallreq_o !== 1'b1 || obs_bus !== 71'h0
            || cpu_data_o !== 32'h0) begin
            bad++;
            $display("FAIL req_cycle: got sr=%b bus=%h d=%h want 1/0/0",
                     stallreq_o, obs_bus, cpu_data_o);
        end
        @(posedge clk);
        #1;
        cpu_ce_i   = 1'b0;
        cpu_addr_i = $urandom;
        cpu_data_i = $urandom;
        cpu_we_i   = ~we;
        cpu_sel_i  = ~sel;
        for (int i = 1; i < dly; i++) begin
            stall_i   = rnd_stall(1'($urandom));
            wb_data_i = $urandom;
            @(negedge clk);
            total++;
            if (obs_bus !== exp_bus || stallreq_o !== 1'b1
                || cpu_data_o !== 32'h0) begin
                bad++;
                $display("FAIL busy_hold: got bus=%h sr=%b d=%h want %h/1/0",
                         obs_bus, stallreq_o, cpu_data_o, exp_bus);
            end
            @(posedge clk);
            #1;
        end
        wb_ack_i  = fl_end ? 1'($urandom) : 1'b1;
        wb_data_i = rd;
        flush_i   = fl_end;
        stall_i   = rnd_stall(n > 0 || (fl_end && 1'($urandom)));
        exp_d     = (fl_end || we) ? 32'h0 : rd;
        @(negedge clk);
        total++;
        if (obs_bus !== exp_bus || stallreq_o !== 1'b0
            || cpu_data_o !== exp_d) begin
            bad++;
            $display("FAIL ack_cycle: got bus=%h sr=%b d=%h want %h/0/%h",
                     obs_bus, stallreq_o, cpu_data_o, exp_bus, exp_d);
        end
        @(posedge clk);
        #1;
        wb_ack_i  = 1'b0;
        flush_i   = 1'b0;
        wb_data_i = $urandom;
        if (fl_end) begin
            stall_i = rnd_stall(1'b0);
            @(negedge clk);
            total++;
            if (dut.rd_buf_q !== 32'h0 || obs_bus !== 71'h0) begin
                bad++;
                $display("FAIL flush_clear: got buf=%h bus=%h want 0/0",
                         dut.rd_buf_q, obs_bus);
            end
        end else begin
            for (int w = 1; w <= n; w++) begin
                stall_i = rnd_stall(fl_wait ? 1'b1 : (w < n));
                flush_i = fl_wait;
                @(negedge clk);
                total++;
                if (obs_bus !== 71'h0 || stallreq_o !== 1'b0
                    || cpu_data_o !== rd) begin
                    bad++;
                    $display("FAIL wait_cycle: got bus=%h sr=%b d=%h want 0/0/%h",
                             obs_bus, stallreq_o, cpu_data_o, rd);
                end
                @(posedge clk);
                #1;
            end
            flush_i = 1'b0;
            stall_i = rnd_stall(1'b0);
        end
        @(negedge clk);
        total++;
        if (obs_bus !== 71'h0 || stallreq_o !== 1'b0
            || cpu_data_o !== 32'h0) begin
            bad++;
            $display("FAIL back_idle: got bus=%h sr=%b d=%h want 0/0/0",
                     obs_bus, stallreq_o, cpu_data_o);
        end
    endtask

    task automatic test_reset_mid_busy();
        @(posedge clk);
        #1;
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0200;
        cpu_sel_i  = 4'hF;
        stall_i    = 6'h0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (wb_cyc_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_busy: got cyc=%b want 1", wb_cyc_o);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || stallreq_o !== 1'b0
            || cpu_data_o !== 32'h0) begin
            bad++;
            $display("FAIL rst_async: got cyc=%b stb=%b sr=%b d=%h want 0",
                     wb_cyc_o, wb_stb_o, stallreq_o, cpu_data_o);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        cpu_ce_i  = 1'b0;
        wb_ack_i  = 1'b1;
        wb_data_i = 32'hCAFE_F00D;
        @(negedge clk);
        total++;
        if (obs_bus !== 71'h0 || cpu_data_o !== 32'h0
            || stallreq_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_late_ack: got bus=%h d=%h sr=%b want 0",
                     obs_bus, cpu_data_o, stallreq_o);
        end
        @(posedge clk);
        #1 wb_ack_i = 1'b0;
        @(negedge clk);
        total++;
        if (obs_bus !== 71'h0 || cpu_data_o !== 32'h0) begin
            bad++;
            $display("FAIL rst_after: got bus=%h d=%h want 0/0",
                     obs_bus, cpu_data_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a[2];
        logic [31:0] rd[2];
        logic [31:0] got[$];
        int          dly;
        a[0]  = $urandom & 32'hFFFF_FFFC;
        a[1]  = $urandom & 32'hFFFF_FFFC;
        rd[0] = $urandom;
        rd[1] = $urandom;
        @(posedge clk);
        #1;
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_sel_i  = 4'hF;
        cpu_addr_i = a[0];
        stall_i    = rnd_stall(1'b0);
        for (int k = 0; k < 2; k++) begin
            dly = int'($urandom_range(1, 3));
            @(negedge clk);
            total++;
            if (wb_cyc_o !== 1'b0 || stallreq_o !== 1'b1) begin
                bad++;
                $display("FAIL b2b_gap%0d: got cyc=%b sr=%b want 0/1",
                         k, wb_cyc_o, stallreq_o);
            end
            @(posedge clk);
            #1;
            @(negedge clk);
            total++;
            if (wb_cyc_o !== 1'b1 || wb_addr_o !== a[k]) begin
                bad++;
                $display("FAIL b2b_rise%0d: got cyc=%b addr=%h want 1/%h",
                         k, wb_cyc_o, wb_addr_o, a[k]);
            end
            for (int i = 1; i < dly; i++) begin
                @(posedge clk);
                #1;
            end
            if (dly > 1) begin
                @(negedge clk);
            end
            wb_ack_i  = 1'b1;
            wb_data_i = rd[k];
            #1;
            got.push_back(cpu_data_o);
            @(posedge clk);
            #1;
            wb_ack_i   = 1'b0;
            cpu_addr_i = a[1];
            if (k == 1) begin
                cpu_ce_i = 1'b0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (got.size() == 0 || got[0] !== rd[k]) begin
                bad++;
                $display("FAIL b2b_data%0d: got %h want %h",
                         k, (got.size() == 0) ? 32'h0 : got[0], rd[k]);
            end
            if (got.size() != 0) begin
                void'(got.pop_front());
            end
        end
        @(negedge clk);
        total++;
        if (obs_bus !== 71'h0 || stallreq_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: got bus=%h sr=%b want 0/0",
                     obs_bus, stallreq_o);
        end
    endtask

    task automatic test_random(input int iters);
        for (int it = 0; it < iters; it++) begin
            test_access(1'($urandom), $urandom, $urandom, $urandom,
                        4'($urandom), int'($urandom_range(1, 4)),
                        int'($urandom_range(0, 3)),
                        ($urandom_range(0, 5) == 0),
                        ($urandom_range(0, 5) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_idle_flush();
        test_access(1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 4'hF,
                    3, 0, 1'b0, 1'b0);
        test_access(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0BAD_0BAD, 4'hF,
                    2, 0, 1'b0, 1'b0);
        test_access(1'b0, 32'h0000_0080, 32'h0, 32'hA5A5_A5A5, 4'hF,
                    1, 2, 1'b0, 1'b0);
        test_access(1'b0, 32'h0000_0044, 32'h0, 32'h7777_8888, 4'h3,
                    2, 0, 1'b1, 1'b0);
        test_access(1'b0, 32'h0000_0048, 32'h0, 32'h9999_AAAA, 4'hC,
                    1, 3, 1'b0, 1'b1);
        test_reset_mid_busy();
        test_back_to_back();
        test_random(30);
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wishbone_bus_if.md
WISHBONE_BUS_IF -- requirements
Module: wishbone_bus_if

Interface
REQ-001 SHALL have parameter STALL_IDX, default 1, giving the stall vector bit this port waits on (1 = instruction port, 3 = data port).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low (`RstEnable).
REQ-004 SHALL have port stall_i  in  6  pipeline stall vector from the stall controller.
REQ-005 SHALL have port flush_i  in  1  exception flush from the stall controller.
REQ-006 SHALL have port cpu_ce_i  in  1  CPU access request.
REQ-007 SHALL have port cpu_addr_i  in  32  byte address.
REQ-008 SHALL have port cpu_data_i  in  32  write data.
REQ-009 SHALL have port cpu_we_i  in  1  1 = write, 0 = read.
REQ-010 SHALL have port cpu_sel_i  in  4  byte lane select.
REQ-011 SHALL have port cpu_data_o  out  32  read data returned to the pipeline.
REQ-012 SHALL have port stallreq_o  out  1  stall request to the stall controller (stallreq_from_if or stallreq_from_mem).
REQ-013 SHALL have ports wb_addr_o  out  32, wb_data_o  out  32, wb_we_o  out  1, wb_sel_o  out  4, wb_stb_o  out  1, wb_cyc_o  out  1  Wishbone master outputs.
REQ-014 SHALL have ports wb_data_i  in  32, wb_ack_i  in  1  Wishbone master inputs.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, BUSY, WAIT_FOR_STALL.
REQ-016 All wb_* outputs and the internal read buffer rd_buf SHALL be registered.
REQ-017 IDLE, cpu_ce_i=1 and flush_i=0: on the next edge, SHALL set wb_stb_o and wb_cyc_o to 1, latch cpu_addr_i, cpu_data_i, cpu_we_i and cpu_sel_i onto the wb_* outputs, and go to BUSY.
REQ-018 IDLE otherwise: SHALL stay in IDLE with all wb_* outputs at 0.
REQ-019 BUSY, wb_ack_i=1 and flush_i=0: on the next edge, SHALL clear all wb_* outputs to 0 and load rd_buf with wb_data_i.
REQ-020 In the same case, SHALL go to WAIT_FOR_STALL if stall_i[STALL_IDX]=1, otherwise to IDLE.
REQ-021 BUSY, wb_ack_i=0 and flush_i=0: SHALL hold all outputs and stay in BUSY; there is no timeout.
REQ-022 BUSY with flush_i=1 (whether or not wb_ack_i=1): SHALL abort; on the next edge, clear all wb_* outputs and rd_buf to 0 and go to IDLE. Flush wins over ack.
REQ-023 WAIT_FOR_STALL: SHALL go to IDLE on the first edge where stall_i[STALL_IDX]=0 or flush_i=1.
REQ-024 stallreq_o is combinational: in IDLE it SHALL equal cpu_ce_i AND NOT flush_i.
REQ-025 In BUSY, stallreq_o SHALL be 0 when wb_ack_i=1 or flush_i=1, and 1 otherwise.
REQ-026 In WAIT_FOR_STALL, stallreq_o SHALL be 0.
REQ-027 cpu_data_o is combinational: in BUSY with wb_ack_i=1, flush_i=0 and wb_we_o=0, it SHALL equal wb_data_i.
REQ-028 In WAIT_FOR_STALL, cpu_data_o SHALL equal rd_buf.
REQ-029 In all other cases, cpu_data_o SHALL be 0.
REQ-030 Minimum access latency SHALL be 2 cycles from cpu_ce_i to data: request cycle, then the ack cycle.
REQ-031 Back-to-back accesses SHALL pass through IDLE for at least one cycle between them, so wb_cyc_o drops for at least one cycle.
REQ-032 wb_stb_o SHALL always equal wb_cyc_o.
REQ-033 No Wishbone output SHALL change while in BUSY until ack or flush.

Reset
REQ-034 rst_n=0 SHALL asynchronously force state=IDLE and clear wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o and rd_buf to 0.
REQ-035 While rst_n=0, stallreq_o SHALL be 0 and cpu_data_o SHALL be 0.
REQ-036 Reset asserted during BUSY SHALL drop wb_cyc_o immediately, without waiting for a clock edge; a later wb_ack_i SHALL be ignored.

Verification
REQ-037 Read with ack 3 cycles after stb, stall_i=0, wb_data_i=0x12345678 -> stallreq_o=1 for 3 cycles; in the ack cycle cpu_data_o=0x12345678 and stallreq_o=0; the next cycle is IDLE with cyc=0.
REQ-038 Write to addr 0x100, data 0xDEADBEEF, sel 0xF -> wb_we_o=1 with the addr/data/sel latched; cpu_data_o=0 in the ack cycle.
REQ-039 Read acked with wb_data_i=0xA5A5A5A5 while stall_i[STALL_IDX]=1 for 2 more cycles -> WAIT_FOR_STALL; cpu_data_o=0xA5A5A5A5 and stallreq_o=0 for both cycles, then IDLE.
REQ-040 flush_i=1 in the BUSY cycle where wb_ack_i=1 -> cpu_data_o=0 and stallreq_o=0; the next edge is IDLE with all wb_* outputs=0 and rd_buf=0.
REQ-041 rst_n pulsed low mid-BUSY -> wb_cyc_o and wb_stb_o=0 asynchronously; a subsequent ack produces no data and no state change.
REQ-042 Two reads with cpu_ce_i held high -> second wb_cyc_o rise exactly 1 idle cycle after the first ack; both data values returned in order.
